// File: rtl/freq_seq_pkg.sv
// Shared definitions for the frequency-profile sequencer: FSM state encoding,
// timing defaults and the bit layout of one profile table entry.
package freq_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_ARM   = 3'd4,
        ST_RUN   = 3'd5,
        ST_NEXT  = 3'd6,
        ST_DONE  = 3'd7
    } seq_state_t;

    // Load strobe length; the generator's edge detector needs at least 3 cycles
    localparam int LOAD_HOLD_DEF   = 4;
    // Cycles allowed for the generator to drop its finished flag after a load
    localparam int ARM_TIMEOUT_DEF = 1024;

    // Table entry layout: {pulse[15:0], pha[31:0], freq[31:0]}
    localparam int FREQ_W    = 32;
    localparam int PHA_W     = 32;
    localparam int PULSE_W   = 16;
    localparam int FREQ_LSB  = 0;
    localparam int PHA_LSB   = FREQ_LSB + FREQ_W;
    localparam int PULSE_LSB = PHA_LSB + PHA_W;
    localparam int ENTRY_W   = PULSE_LSB + PULSE_W;

    // Assemble one table entry from its three fields
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [FREQ_W-1:0]  freq,
        input logic [PHA_W-1:0]   pha,
        input logic [PULSE_W-1:0] pulse
    );
        return {pulse, pha, freq};
    endfunction

endpackage

// File: rtl/freq_profile_table.sv
// Profile step table: DEPTH entries written by the host at any time and read
// combinationally at the sequencer's current step index. Contents survive reset.
module freq_profile_table
    import freq_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                 I_clk,
    input  logic                 I_wr_en,
    input  logic [AW-1:0]        I_wr_addr,
    input  logic [31:0]          I_wr_freq,
    input  logic [31:0]          I_wr_pha,
    input  logic [15:0]          I_wr_pulse,
    input  logic [AW-1:0]        I_rd_addr,
    output logic [ENTRY_W-1:0]   O_rd_entry
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];

    // Host write port; no reset so a programmed profile survives a reset
    always_ff @(posedge I_clk) begin
        if (I_wr_en) begin
            mem_r[I_wr_addr] <= pack_entry(I_wr_freq, I_wr_pha, I_wr_pulse);
        end
    end

    assign O_rd_entry = mem_r[I_rd_addr];

endmodule

// File: rtl/freq_profile_seq.sv
// Frequency profile sequencer: walks the generator through the programmed
// steps in limited-pulse mode, waiting for each step's pulses to finish.
module freq_profile_seq
    import freq_seq_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int LOAD_HOLD   = LOAD_HOLD_DEF,
    parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF
) (
    input  logic          I_clk,
    input  logic          I_reset,
    input  logic          I_wr_en,
    input  logic [AW-1:0] I_wr_addr,
    input  logic [31:0]   I_wr_freq,
    input  logic [31:0]   I_wr_pha,
    input  logic [15:0]   I_wr_pulse,
    input  logic [AW-1:0] I_step_last,
    input  logic          I_loop,
    input  logic          I_start,
    input  logic          I_abort,
    input  logic          I_finished,
    output logic [31:0]   O_freq,
    output logic [31:0]   O_pha,
    output logic [1:0]    O_load,
    output logic          O_stat,
    output logic [15:0]   O_pluse_number,
    output logic          O_limited_Pluse,
    output logic [31:0]   O_init_pulse,
    output logic [AW-1:0] O_step_idx,
    output logic          O_busy,
    output logic          O_done,
    output logic          O_err
);

    localparam int HW = $clog2(LOAD_HOLD + 1);
    localparam int TW = $clog2(ARM_TIMEOUT + 1);

    seq_state_t         state_r;
    logic [AW-1:0]      step_idx_r;
    logic [HW-1:0]      hold_cnt_r;
    logic [TW-1:0]      tmo_cnt_r;
    logic               start_d_r;
    logic               fin_s1_r;
    logic               fin_s2_r;
    logic               start_edge_s;
    logic               hold_done_s;
    logic               tmo_done_s;
    logic [ENTRY_W-1:0] rd_entry_s;
    logic [31:0]        rd_freq_s;
    logic [31:0]        rd_pha_s;
    logic [15:0]        rd_pulse_s;

    freq_profile_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .I_clk      (I_clk),
        .I_wr_en    (I_wr_en),
        .I_wr_addr  (I_wr_addr),
        .I_wr_freq  (I_wr_freq),
        .I_wr_pha   (I_wr_pha),
        .I_wr_pulse (I_wr_pulse),
        .I_rd_addr  (step_idx_r),
        .O_rd_entry (rd_entry_s)
    );

    assign rd_freq_s    = rd_entry_s[FREQ_LSB +: FREQ_W];
    assign rd_pha_s     = rd_entry_s[PHA_LSB +: PHA_W];
    assign rd_pulse_s   = rd_entry_s[PULSE_LSB +: PULSE_W];

    // The generator counter is always cleared to zero at profile start
    assign O_init_pulse = 32'd0;
    assign O_step_idx   = step_idx_r;

    assign start_edge_s = I_start & ~start_d_r;
    assign hold_done_s  = (hold_cnt_r == HW'(LOAD_HOLD - 1));
    assign tmo_done_s   = (tmo_cnt_r == TW'(ARM_TIMEOUT - 1));

    // Start edge history and two-flop synchroniser for the generator finished flag
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            start_d_r <= 1'b0;
            fin_s1_r  <= 1'b0;
            fin_s2_r  <= 1'b0;
        end else begin
            start_d_r <= I_start;
            fin_s1_r  <= I_finished;
            fin_s2_r  <= fin_s1_r;
        end
    end

    // Sequencer FSM with registered generator-facing and status outputs
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_r         <= ST_IDLE;
            step_idx_r      <= '0;
            hold_cnt_r      <= '0;
            tmo_cnt_r       <= '0;
            O_freq          <= 32'd0;
            O_pha           <= 32'd0;
            O_load          <= 2'b00;
            O_stat          <= 1'b0;
            O_pluse_number  <= 16'd0;
            O_limited_Pluse <= 1'b0;
            O_busy          <= 1'b0;
            O_done          <= 1'b0;
            O_err           <= 1'b0;
        end else if (I_abort) begin
            // Abort wins over start and every state transition
            state_r         <= ST_IDLE;
            hold_cnt_r      <= '0;
            tmo_cnt_r       <= '0;
            O_load          <= 2'b00;
            O_stat          <= 1'b0;
            O_limited_Pluse <= 1'b0;
            O_busy          <= 1'b0;
            O_done          <= 1'b0;
        end else begin
            O_done <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // Start while busy never reaches here, so it is ignored
                    if (start_edge_s) begin
                        step_idx_r <= '0;
                        hold_cnt_r <= '0;
                        O_err      <= 1'b0;
                        O_stat     <= 1'b1;
                        O_load     <= 2'b10;
                        O_busy     <= 1'b1;
                        state_r    <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (hold_done_s) begin
                        O_load  <= 2'b00;
                        state_r <= ST_FETCH;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                ST_FETCH: begin
                    // A zero pulse count skips the step without touching the generator
                    if (rd_pulse_s == 16'd0) begin
                        state_r <= ST_NEXT;
                    end else begin
                        O_freq          <= rd_freq_s;
                        O_pha           <= rd_pha_s;
                        O_pluse_number  <= rd_pulse_s;
                        O_limited_Pluse <= 1'b1;
                        O_load          <= 2'b01;
                        hold_cnt_r      <= '0;
                        state_r         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (hold_done_s) begin
                        O_load    <= 2'b00;
                        tmo_cnt_r <= '0;
                        state_r   <= ST_ARM;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                ST_ARM: begin
                    // Finished dropping low means the generator took the new count
                    if (!fin_s2_r) begin
                        state_r <= ST_RUN;
                    end else if (tmo_done_s) begin
                        O_err           <= 1'b1;
                        O_stat          <= 1'b0;
                        O_limited_Pluse <= 1'b0;
                        O_busy          <= 1'b0;
                        state_r         <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                ST_RUN: begin
                    if (fin_s2_r) begin
                        state_r <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (step_idx_r != I_step_last) begin
                        step_idx_r <= step_idx_r + AW'(1);
                        state_r    <= ST_FETCH;
                    end else if (I_loop) begin
                        step_idx_r <= '0;
                        state_r    <= ST_FETCH;
                    end else begin
                        // Generator keeps O_stat and its finished level while in DONE
                        O_done  <= 1'b1;
                        O_busy  <= 1'b0;
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    O_load          <= 2'b00;
                    O_stat          <= 1'b0;
                    O_limited_Pluse <= 1'b0;
                    O_busy          <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_profile_seq.sv
// Self-checking bench for freq_profile_seq with a behavioural generator model
// and a step-list reference model derived from the profile rules.
module tb_freq_profile_seq;

    localparam int AW = 3;

    logic          I_clk = 1'b0;
    logic          I_reset = 1'b1;
    logic          I_wr_en = 1'b0;
    logic [AW-1:0] I_wr_addr = '0;
    logic [31:0]   I_wr_freq = 32'd0;
    logic [31:0]   I_wr_pha = 32'd0;
    logic [15:0]   I_wr_pulse = 16'd0;
    logic [AW-1:0] I_step_last = '0;
    logic          I_loop = 1'b0;
    logic          I_start = 1'b0;
    logic          I_abort = 1'b0;
    logic          I_finished;
    logic [31:0]   O_freq, O_pha, O_init_pulse;
    logic [1:0]    O_load;
    logic          O_stat, O_limited_Pluse, O_busy, O_done, O_err;
    logic [15:0]   O_pluse_number;
    logic [AW-1:0] O_step_idx;

    freq_profile_seq dut (
        .I_clk(I_clk), .I_reset(I_reset), .I_wr_en(I_wr_en), .I_wr_addr(I_wr_addr),
        .I_wr_freq(I_wr_freq), .I_wr_pha(I_wr_pha), .I_wr_pulse(I_wr_pulse),
        .I_step_last(I_step_last), .I_loop(I_loop), .I_start(I_start), .I_abort(I_abort),
        .I_finished(I_finished), .O_freq(O_freq), .O_pha(O_pha), .O_load(O_load),
        .O_stat(O_stat), .O_pluse_number(O_pluse_number), .O_limited_Pluse(O_limited_Pluse),
        .O_init_pulse(O_init_pulse), .O_step_idx(O_step_idx), .O_busy(O_busy),
        .O_done(O_done), .O_err(O_err)
    );

    always #20 I_clk = ~I_clk;

    typedef struct {
        logic [31:0] f;
        logic [31:0] p;
        logic [15:0] n;
        int          idx;
    } ld_t;

    // Reference copy of the table and expected load list
    logic [31:0] m_freq [8];
    logic [31:0] m_pha  [8];
    logic [15:0] m_pulse[8];
    ld_t exp_q[$];
    int  exp_total;

    // Observations
    ld_t obs_q[$];
    int  obs_w_q[$];
    int  init_w_q[$];
    int  spd1_cnt = 0;
    int  done_cnt = 0;
    int  w_l0 = 0, w_l1 = 0;
    logic prev_l0 = 1'b0, prev_l1 = 1'b0;

    // Generator model
    bit   gen_tie1 = 1'b0;
    logic gen_fin = 1'b1;
    int   gen_rem = 0, gen_ph = 0, gen_per = 3;

    int n_vec = 0;
    int n_err = 0;

    assign I_finished = gen_tie1 ? 1'b1 : gen_fin;

    // Monitor and generator model, evaluated on the falling edge
    always @(negedge I_clk) begin
        ld_t e;
        if (O_load[0]) begin
            if (!prev_l0) begin
                e.f = O_freq; e.p = O_pha; e.n = O_pluse_number; e.idx = int'(O_step_idx);
                obs_q.push_back(e);
                gen_rem = int'(O_pluse_number);
                gen_fin = 1'b0;
                gen_ph  = 0;
                gen_per = 3 + int'(O_freq[1:0]);
            end
            w_l0++;
        end else begin
            if (prev_l0) begin
                obs_w_q.push_back(w_l0);
                w_l0 = 0;
            end
            if (O_stat && O_limited_Pluse && gen_rem > 0) begin
                gen_ph++;
                if (gen_ph >= gen_per) begin
                    gen_ph = 0;
                    gen_rem--;
                    spd1_cnt++;
                    if (gen_rem == 0) gen_fin = 1'b1;
                end
            end
        end
        if (O_load[1]) w_l1++;
        else if (prev_l1) begin
            init_w_q.push_back(w_l1);
            w_l1 = 0;
        end
        if (O_done) done_cnt++;
        prev_l0 = O_load[0];
        prev_l1 = O_load[1];
    end

    task automatic wr_step(input int i, input logic [31:0] f, input logic [31:0] p, input logic [15:0] n);
        I_wr_en = 1'b1; I_wr_addr = AW'(i); I_wr_freq = f; I_wr_pha = p; I_wr_pulse = n;
        @(negedge I_clk);
        I_wr_en = 1'b0;
        m_freq[i] = f; m_pha[i] = p; m_pulse[i] = n;
    endtask

    task automatic build_expected(input int last);
        ld_t e;
        exp_q.delete();
        exp_total = 0;
        for (int i = 0; i <= last; i++) begin
            if (m_pulse[i] != 16'd0) begin
                e.f = m_freq[i]; e.p = m_pha[i]; e.n = m_pulse[i]; e.idx = i;
                exp_q.push_back(e);
                exp_total += int'(m_pulse[i]);
            end
        end
    endtask

    task automatic clear_obs();
        obs_q.delete(); obs_w_q.delete(); init_w_q.delete();
        spd1_cnt = 0; done_cnt = 0;
    endtask

    task automatic pulse_start();
        I_start = 1'b1;
        @(negedge I_clk);
        I_start = 1'b0;
    endtask

    task automatic write_fixed(input bit skip1);
        wr_step(0, 32'd1000, 32'd250, 16'd5);
        wr_step(1, 32'd500, 32'd125, skip1 ? 16'd0 : 16'd3);
        wr_step(2, 32'd2000, 32'd500, 16'd2);
        I_step_last = AW'(2);
        I_loop = 1'b0;
    endtask

    task automatic test_reset();
        logic [121:0] all_s;
        I_reset = 1'b1;
        repeat (3) @(negedge I_clk);
        all_s = {O_freq, O_pha, O_load, O_stat, O_pluse_number, O_limited_Pluse,
                 O_init_pulse, O_step_idx, O_busy, O_done, O_err};
        n_vec++;
        if (all_s !== 122'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h required 0", all_s);
        end
        I_reset = 1'b0;
        @(negedge I_clk);
    endtask

    // Runs one non-looping profile and compares it with the reference step list
    task automatic test_profile_run(input bit rnd, input bit skip1);
        int last;
        int c;
        int n500;
        if (rnd) begin
            last = int'($urandom_range(7, 1));
            for (int i = 0; i <= last; i++)
                wr_step(i, $urandom, $urandom, 16'($urandom_range(5, 0)));
            I_step_last = AW'(last);
            I_loop = 1'b0;
        end else begin
            write_fixed(skip1);
            last = 2;
        end
        build_expected(last);
        clear_obs();
        pulse_start();
        c = 0;
        while (done_cnt == 0 && c < 5000) begin @(negedge I_clk); c++; end
        repeat (3) @(negedge I_clk);
        n_vec++;
        if (done_cnt != 1) begin
            n_err++; $display("FAIL profile_done_count: got %0d required 1", done_cnt);
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL profile_load_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_vec++;
                if (obs_q[k].f !== exp_q[k].f || obs_q[k].p !== exp_q[k].p ||
                    obs_q[k].n !== exp_q[k].n || obs_q[k].idx != exp_q[k].idx) begin
                    n_err++;
                    $display("FAIL profile_load_%0d: got f=%0d p=%0d n=%0d i=%0d required f=%0d p=%0d n=%0d i=%0d",
                             k, obs_q[k].f, obs_q[k].p, obs_q[k].n, obs_q[k].idx,
                             exp_q[k].f, exp_q[k].p, exp_q[k].n, exp_q[k].idx);
                end
            end
        end
        foreach (obs_w_q[k]) begin
            n_vec++;
            if (obs_w_q[k] != 4) begin
                n_err++; $display("FAIL load0_width: got %0d required 4", obs_w_q[k]);
            end
        end
        n_vec++;
        if (init_w_q.size() != 1 || init_w_q[0] != 4) begin
            n_err++; $display("FAIL init_strobe: got %0d strobes required one of 4 cycles", init_w_q.size());
        end
        n_vec++;
        if (spd1_cnt != exp_total) begin
            n_err++; $display("FAIL pulse_total: got %0d required %0d", spd1_cnt, exp_total);
        end
        if (skip1) begin
            n500 = 0;
            foreach (obs_q[k]) if (obs_q[k].f == 32'd500) n500++;
            n_vec++;
            if (n500 != 0) begin
                n_err++; $display("FAIL skip_step1: got %0d loads of freq 500 required 0", n500);
            end
        end
        n_vec++;
        if (O_busy !== 1'b0 || O_stat !== 1'b1 || O_err !== 1'b0 || O_step_idx !== AW'(last)) begin
            n_err++;
            $display("FAIL done_state: got busy=%b stat=%b err=%b idx=%0d required 0 1 0 %0d",
                     O_busy, O_stat, O_err, O_step_idx, last);
        end
    endtask

    task automatic test_loop_abort();
        int c;
        int d0;
        wr_step(0, $urandom, $urandom, 16'($urandom_range(4, 2)));
        wr_step(1, $urandom, $urandom, 16'($urandom_range(4, 2)));
        I_step_last = AW'(1);
        I_loop = 1'b1;
        clear_obs();
        pulse_start();
        c = 0;
        while (obs_q.size() < 5 && c < 3000) begin @(negedge I_clk); c++; end
        c = 0;
        while (O_load[0] && c < 20) begin @(negedge I_clk); c++; end
        repeat (2) @(negedge I_clk);
        n_vec++;
        if (obs_q.size() < 5) begin
            n_err++; $display("FAIL loop_progress: got %0d loads required 5", obs_q.size());
        end
        foreach (obs_q[k]) begin
            n_vec++;
            if (obs_q[k].idx != k % 2) begin
                n_err++; $display("FAIL loop_step_idx_%0d: got %0d required %0d", k, obs_q[k].idx, k % 2);
            end
        end
        n_vec++;
        if (O_busy !== 1'b1) begin
            n_err++; $display("FAIL loop_busy: got %b required 1", O_busy);
        end
        d0 = done_cnt;
        I_abort = 1'b1;
        @(negedge I_clk);
        I_abort = 1'b0;
        n_vec++;
        if (O_busy !== 1'b0 || O_stat !== 1'b0 || O_load !== 2'b00 || O_limited_Pluse !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: got busy=%b stat=%b load=%b lim=%b required 0 0 00 0",
                     O_busy, O_stat, O_load, O_limited_Pluse);
        end
        repeat (10) @(negedge I_clk);
        n_vec++;
        if (done_cnt != d0 || O_busy !== 1'b0) begin
            n_err++; $display("FAIL abort_quiet: got done=%0d busy=%b required %0d 0", done_cnt, O_busy, d0);
        end
        I_loop = 1'b0;
    endtask

    task automatic test_timeout();
        int c;
        wr_step(0, 32'd777, 32'd0, 16'd2);
        I_step_last = AW'(0);
        I_loop = 1'b0;
        gen_tie1 = 1'b1;
        pulse_start();
        c = 0;
        while (!O_load[0] && c < 50) begin @(negedge I_clk); c++; end
        c = 0;
        while (O_load[0] && c < 50) begin @(negedge I_clk); c++; end
        c = 0;
        while (c < 2000) begin
            @(negedge I_clk); c++;
            if (O_err) break;
        end
        n_vec++;
        if (c != 1024) begin
            n_err++; $display("FAIL arm_timeout_cycles: got %0d required 1024", c);
        end
        n_vec++;
        if (O_err !== 1'b1 || O_busy !== 1'b0 || O_stat !== 1'b0) begin
            n_err++; $display("FAIL timeout_state: got err=%b busy=%b stat=%b required 1 0 0", O_err, O_busy, O_stat);
        end
        repeat (5) @(negedge I_clk);
        n_vec++;
        if (O_err !== 1'b1) begin
            n_err++; $display("FAIL err_sticky: got %b required 1", O_err);
        end
        pulse_start();
        n_vec++;
        if (O_err !== 1'b0 || O_busy !== 1'b1) begin
            n_err++; $display("FAIL err_clear_on_start: got err=%b busy=%b required 0 1", O_err, O_busy);
        end
        I_abort = 1'b1;
        @(negedge I_clk);
        I_abort = 1'b0;
        gen_tie1 = 1'b0;
        @(negedge I_clk);
    endtask

    task automatic test_back_to_back();
        int c;
        logic [AW-1:0] idx0;
        write_fixed(1'b0);
        build_expected(2);
        clear_obs();
        pulse_start();
        c = 0;
        while (obs_q.size() < 2 && c < 2000) begin @(negedge I_clk); c++; end
        c = 0;
        while (O_load[0] && c < 20) begin @(negedge I_clk); c++; end
        repeat (2) @(negedge I_clk);
        idx0 = O_step_idx;
        pulse_start();
        @(negedge I_clk);
        n_vec++;
        if (O_step_idx !== idx0 || O_busy !== 1'b1 || init_w_q.size() != 1 || idx0 !== AW'(1)) begin
            n_err++;
            $display("FAIL start_while_run: got idx=%0d busy=%b inits=%0d required idx=1 busy=1 inits=1",
                     O_step_idx, O_busy, init_w_q.size());
        end
        c = 0;
        while (done_cnt == 0 && c < 5000) begin @(negedge I_clk); c++; end
        repeat (2) @(negedge I_clk);
        n_vec++;
        if (done_cnt != 1 || obs_q.size() != exp_q.size() || spd1_cnt != exp_total) begin
            n_err++;
            $display("FAIL run_after_ignored_start: got done=%0d loads=%0d pulses=%0d required 1 %0d %0d",
                     done_cnt, obs_q.size(), spd1_cnt, exp_q.size(), exp_total);
        end
        I_abort = 1'b1;
        @(negedge I_clk);
        I_abort = 1'b0;
        @(negedge I_clk);
        I_start = 1'b1;
        I_abort = 1'b1;
        @(negedge I_clk);
        I_start = 1'b0;
        I_abort = 1'b0;
        repeat (3) @(negedge I_clk);
        n_vec++;
        if (O_busy !== 1'b0 || O_stat !== 1'b0 || init_w_q.size() != 1 || O_load !== 2'b00) begin
            n_err++;
            $display("FAIL start_abort_same_cycle: got busy=%b stat=%b inits=%0d required 0 0 1",
                     O_busy, O_stat, init_w_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        int c;
        logic [121:0] all_s;
        write_fixed(1'b0);
        build_expected(2);
        pulse_start();
        c = 0;
        while (!O_load[0] && c < 50) begin @(negedge I_clk); c++; end
        #5 I_reset = 1'b1;
        #1;
        all_s = {O_freq, O_pha, O_load, O_stat, O_pluse_number, O_limited_Pluse,
                 O_init_pulse, O_step_idx, O_busy, O_done, O_err};
        n_vec++;
        if (all_s !== 122'd0 || c >= 50) begin
            n_err++; $display("FAIL async_reset_mid_load: got %h required 0", all_s);
        end
        repeat (2) @(negedge I_clk);
        I_reset = 1'b0;
        @(negedge I_clk);
        clear_obs();
        pulse_start();
        c = 0;
        while (done_cnt == 0 && c < 5000) begin @(negedge I_clk); c++; end
        repeat (2) @(negedge I_clk);
        n_vec++;
        if (done_cnt != 1 || obs_q.size() != exp_q.size() || spd1_cnt != exp_total) begin
            n_err++;
            $display("FAIL replay_after_reset: got done=%0d loads=%0d pulses=%0d required 1 %0d %0d",
                     done_cnt, obs_q.size(), spd1_cnt, exp_q.size(), exp_total);
        end else begin
            foreach (exp_q[k]) begin
                n_vec++;
                if (obs_q[k].f !== exp_q[k].f || obs_q[k].n !== exp_q[k].n) begin
                    n_err++;
                    $display("FAIL replay_load_%0d: got f=%0d n=%0d required f=%0d n=%0d",
                             k, obs_q[k].f, obs_q[k].n, exp_q[k].f, exp_q[k].n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_profile_run(1'b0, 1'b0);
        test_profile_run(1'b0, 1'b1);
        test_profile_run(1'b1, 1'b0);
        test_profile_run(1'b1, 1'b0);
        test_loop_abort();
        test_timeout();
        test_back_to_back();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
